// File: rtl/uart_tx_unit.sv
// UART transmitter: 1 start bit, DBIT data bits LSB-first, SB_TICK/16 stop bits,
// no parity, with its own 16x-oversampled baud tick generator.
// Requires CLK_FREQ / (16*BAUD) >= 2 so the end-of-frame pulse can be registered.
module uart_tx_unit #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int unsigned DIV      = CLK_FREQ / (16 * BAUD);
    localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DIV_PRE  = (DIV > 1) ? DIV - 2 : 0;
    localparam int unsigned TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned TICK_W   = $clog2(TICK_MAX);
    localparam int unsigned BIT_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    baud_q, baud_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DBIT-1:0]     shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                s_tick;

    // Baud divider: parked at 0 while idle, so every frame starts phase-aligned.
    always_comb begin
        baud_d = baud_q;
        s_tick = 1'b0;
        if (state_q == IDLE) begin
            baud_d = '0;
        end else if (baud_q == DIV_W'(DIV - 1)) begin
            baud_d = '0;
            s_tick = 1'b1;
        end else begin
            baud_d = baud_q + DIV_W'(1);
        end
    end

    // Frame sequencing: next state, oversample/bit counters and shift register.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shreg_d = tx_din;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(15)) begin
                        tick_d  = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(15)) begin
                        tick_d  = '0;
                        shreg_d = shreg_q >> 1;
                        if (bit_q == BIT_W'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(SB_TICK - 1)) begin
                        tick_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output look-ahead: line/busy follow next state; done fires one cycle before the last stop tick.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (tick_q == TICK_W'(SB_TICK - 1))
                 && (baud_q == DIV_W'(DIV_PRE));
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: two instances (8N1 and 7-bit/2-stop), DIV=10, bit = 160 cycles.
module tb_uart_tx_unit;

    localparam int DIV = 10;
    localparam int BIT_T = 16 * DIV;

    typedef struct {
        logic [8:0] data;
        int         dbit;
        int         sb;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, start_a, start_b;
    logic [7:0] din_a;
    logic [6:0] din_b;
    logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
    logic       tx_m, busy_m, done_m;
    int         sel;
    int         n_vec = 0;
    int         n_bad = 0;
    frame_t     sb_q[$];

    always #5 clk = ~clk;

    uart_tx_unit #(.CLK_FREQ(160), .BAUD(1), .DBIT(8), .SB_TICK(16)) u_a (
        .clk(clk), .reset_n(rst_a), .tx_start(start_a), .tx_din(din_a),
        .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );

    uart_tx_unit #(.CLK_FREQ(160), .BAUD(1), .DBIT(7), .SB_TICK(32)) u_b (
        .clk(clk), .reset_n(rst_b), .tx_start(start_b), .tx_din(din_b),
        .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    always_comb begin
        tx_m   = (sel == 1) ? tx_b   : tx_a;
        busy_m = (sel == 1) ? busy_b : busy_a;
        done_m = (sel == 1) ? done_b : done_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle line for n cycles: high, not busy, no done pulse.
    task automatic check_idle(input int which, input int n, input string tag);
        logic tx_bad, busy_bad;
        int   dn;
        sel = which;
        tx_bad = 1'b0; busy_bad = 1'b0; dn = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx_m !== 1'b1) tx_bad = 1'b1;
            if (busy_m !== 1'b0) busy_bad = 1'b1;
            if (done_m !== 1'b0) dn++;
        end
        check({tag, "_tx_low"}, 32'(tx_bad), 0);
        check({tag, "_busy"}, 32'(busy_bad), 0);
        check({tag, "_done_cnt"}, 32'(dn), 0);
    endtask

    // Called right after the start cycle is driven; checks cycle 0 through the done cycle.
    task automatic check_frame(input int which);
        frame_t f;
        logic   exp_bit, obs_bit, bad, busy_bad;
        int     len, k, done_cnt, done_at;
        sel = which;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        f = sb_q.pop_front();
        @(negedge clk);
        check("cyc0_tx", 32'(tx_m), 1);
        check("cyc0_busy", 32'(busy_m), 0);
        k = 0; done_cnt = 0; done_at = -1; busy_bad = 1'b0;
        for (int seg = 0; seg <= f.dbit + 1; seg++) begin
            if (seg == 0) exp_bit = 1'b0;
            else if (seg <= f.dbit) exp_bit = f.data[seg-1];
            else exp_bit = 1'b1;
            len = (seg == f.dbit + 1) ? f.sb * DIV : BIT_T;
            bad = 1'b0; obs_bit = exp_bit;
            repeat (len) begin
                @(negedge clk);
                k++;
                if (tx_m !== exp_bit && !bad) begin
                    bad = 1'b1;
                    obs_bit = tx_m;
                end
                if (busy_m !== 1'b1) busy_bad = 1'b1;
                if (done_m !== 1'b0) begin
                    done_cnt++;
                    done_at = k;
                end
            end
            check($sformatf("seg%0d_tx", seg), 32'(obs_bit), 32'(exp_bit));
        end
        check("busy_drop", 32'(busy_bad), 0);
        check("done_cnt", 32'(done_cnt), 1);
        check("done_cycle", 32'(done_at), 32'((1 + f.dbit) * BIT_T + f.sb * DIV));
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        din_a = '0; din_b = '0; sel = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_a), 1);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_b_tx", 32'(tx_b), 1);
        rst_a = 1'b1; rst_b = 1'b1;

        // 1: long idle
        check_idle(0, 500, "t1_a");
        check_idle(1, 20, "t1_b");

        // 2: single A5 frame
        @(posedge clk); #1;
        sb_q.push_back('{9'h0A5, 8, 16});
        din_a = 8'hA5; start_a = 1'b1;
        fork
            check_frame(0);
            begin @(posedge clk); #1 start_a = 1'b0; end
        join
        check_idle(0, 5, "t2_after");

        // 3: retriggers mid-frame with new data are ignored
        @(posedge clk); #1;
        sb_q.push_back('{9'h0A5, 8, 16});
        din_a = 8'hA5; start_a = 1'b1;
        fork
            check_frame(0);
            begin
                @(posedge clk); #1 start_a = 1'b0;
                repeat (299) @(posedge clk);
                #1 start_a = 1'b1; din_a = 8'h3C;
                @(posedge clk); #1 start_a = 1'b0;
                repeat (599) @(posedge clk);
                #1 start_a = 1'b1;
                @(posedge clk); #1 start_a = 1'b0;
            end
        join
        check_idle(0, 5, "t3_after");

        // 4: start held high -> back-to-back frames with one idle cycle between
        @(posedge clk); #1;
        sb_q.push_back('{9'h055, 8, 16});
        sb_q.push_back('{9'h055, 8, 16});
        din_a = 8'h55; start_a = 1'b1;
        check_frame(0);
        check_frame(0);
        start_a = 1'b0;
        check_idle(0, 20, "t4_after");

        // 5: 7 data bits, 2 stop bits
        @(posedge clk); #1;
        sb_q.push_back('{9'h041, 7, 32});
        din_b = 7'h41; start_b = 1'b1;
        fork
            check_frame(1);
            begin @(posedge clk); #1 start_b = 1'b0; end
        join
        check_idle(1, 5, "t5_after");

        // 6: reset mid-frame, then a clean frame
        @(posedge clk); #1;
        din_a = 8'h96; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (700) @(negedge clk);
        check("t6_pre_busy", 32'(busy_a), 1);
        check("t6_pre_tx", 32'(tx_a), 0);
        #1 rst_a = 1'b0;
        #1;
        check("t6_async_tx", 32'(tx_a), 1);
        check("t6_async_busy", 32'(busy_a), 0);
        check("t6_async_done", 32'(done_a), 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        check_idle(0, 2000, "t6_post");
        @(posedge clk); #1;
        sb_q.push_back('{9'h0C3, 8, 16});
        din_a = 8'hC3; start_a = 1'b1;
        fork
            check_frame(0);
            begin @(posedge clk); #1 start_a = 1'b0; end
        join
        check_idle(0, 5, "t6_after");

        check("scoreboard_left", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
UART transmitter that consumes the single-cycle `p_edge` pulse from the button conditioning stage as its `tx_start` trigger.
- Serialises one parallel word per accepted trigger: 1 start bit, DBIT data bits LSB-first, configurable stop length, no parity.
- Contains its own 16x-oversampled baud tick generator.
- Drives the board's USB-UART TX pin.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- DBIT, 8: data bits per frame (5..9).
- SB_TICK, 16: stop length in baud ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk, input, 1: system clock, all logic on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- tx_start, input, 1: single-cycle start request, driven from button `p_edge`.
- tx_din, input, DBIT: word to transmit, sampled on acceptance.
- tx, output, 1: serial line, registered, idle high.
- tx_busy, output, 1: high while a frame is in progress.
- tx_done_tick, output, 1: one-cycle pulse at the end of the stop period.

Behaviour:
- Tick generator:
  - DIV = CLK_FREQ / (16*BAUD), integer floor. Default is 651.
  - Counter 0..DIV-1 emits `s_tick` for one cycle when it reaches DIV-1.
  - Counter is held at 0 in IDLE and cleared on acceptance, so a bit lasts exactly 16*DIV cycles. Default bit time is 10416 cycles.
  - Width is $clog2(DIV).
- Reset (async, while reset_n=0):
  - State = IDLE, tx=1, tx_busy=0, tx_done_tick=0.
  - All counters and the shift register = 0.
  - Applies at any point, including mid-frame: the line returns high immediately and the partial frame is abandoned.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - tx_start=1 is accepted: latch tx_din into the shift register, clear the tick-count (0..15) and bit-count (0..DBIT-1), go to START.
  - tx_start is ignored in every other state; no queuing.
- START:
  - tx=0 from the cycle after acceptance.
  - After 16 s_ticks, go to DATA with tick-count=0.
- DATA:
  - tx = shift register bit 0.
  - Each 16 s_ticks: shift right and increment bit-count.
  - After bit DBIT-1 completes, go to STOP.
- STOP:
  - tx=1.
  - After SB_TICK s_ticks: tx_done_tick=1 for exactly that one cycle, return to IDLE.
- tx_busy is 1 from the cycle after acceptance through the tx_done_tick cycle inclusive.
- tx is a registered output with no glitches; tx=0 appears exactly 1 cycle after the tx_start cycle.
- Frame length = (1+DBIT)*16*DIV + SB_TICK*DIV cycles. Default is 104160 cycles.
- Back-to-back frames:
  - tx_start in the tx_done_tick cycle is ignored.
  - tx_start in the following cycle (IDLE) is accepted.
  - Minimum gap between frames is one idle-high cycle.
- tx_din changes after acceptance have no effect on the frame in flight.

Test Plan:
Sim parameters CLK_FREQ=160, BAUD=1, so DIV=10 and bit time = 160 cycles.
1. Reset, then idle for 500 cycles -> tx=1, tx_busy=0, tx_done_tick never asserted.
2. tx_din=8'hA5, one-cycle tx_start -> next cycle tx=0 for 160 cycles, then bits 1,0,1,0,0,1,0,1 for 160 cycles each, stop high for 160. tx_done_tick pulses at cycle 1600 after the start cycle; tx_busy high for exactly cycles 1..1600.
3. tx_start pulsed again at cycles 300 and 900 of a frame, with tx_din changed to 8'h3C -> ignored; the frame still carries 8'hA5 and exactly one tx_done_tick.
4. tx_start held high continuously with tx_din=8'h55 -> consecutive frames separated by exactly one idle-high cycle; each frame is 1600 cycles.
5. SB_TICK=32, DBIT=7, tx_din=7'h41 -> 8*160 + 320 = 1600-cycle frame with a 320-cycle stop.
6. reset_n deasserted at cycle 700 of a frame, then released -> tx=1 and tx_busy=0 asynchronously, no tx_done_tick; a new tx_start then yields a correct full frame.
